// File: rtl/fifo_stream_reader.sv
// Read-side drain engine: pops a registered-output FIFO and re-presents the words
// on a valid/ready stream through a 2-entry skid buffer.
module fifo_stream_reader #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 fifo_empty,
    output logic                 fifo_pop,
    input  logic [WIDTH-1:0]     fifo_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH-1:0]     m_data,
    output logic                 idle,
    output logic [CNT_WIDTH-1:0] drain_count
);

    logic [WIDTH-1:0] buf_mem [0:1];
    logic             head;
    logic             tail;
    logic [1:0]       cnt;
    logic             inflight;
    logic             hs;
    logic [1:0]       occ;

    // Words already owned by this block: buffered plus the one the FIFO is returning.
    assign occ = cnt + {1'b0, inflight};
    assign hs  = m_valid & m_ready;

    // A pop is allowed into a full reservation only when a slot frees up this same cycle.
    // Gating with reset_n keeps the request quiet while the block is held in reset.
    assign fifo_pop = reset_n & enable & ~fifo_empty &
                      ((occ < 2'd2) | ((occ == 2'd2) & hs));

    assign m_valid = (cnt != 2'd0);
    assign m_data  = buf_mem[head];
    assign idle    = (cnt == 2'd0) & ~inflight;

    // NOTE: the two buffer words are reset too so m_data reads zero out of reset;
    // at this depth that costs nothing and keeps the stream output deterministic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_mem[0]  <= '0;
            buf_mem[1]  <= '0;
            head        <= 1'b0;
            tail        <= 1'b0;
            cnt         <= 2'd0;
            inflight    <= 1'b0;
            drain_count <= '0;
        end else begin
            inflight <= fifo_pop;
            if (inflight) begin
                buf_mem[tail] <= fifo_data;
                tail          <= ~tail;
            end
            if (hs) begin
                head        <= ~head;
                drain_count <= drain_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
            // Capture and handshake together leave the occupancy unchanged.
            case ({inflight, hs})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a registered-output FIFO model and an
// in-order scoreboard of popped words.
module tb_fifo_stream_reader;

    localparam int WIDTH     = 16;
    localparam int CNT_WIDTH = 16;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 enable;
    logic                 fifo_empty = 1'b1;
    logic                 fifo_pop;
    logic [WIDTH-1:0]     fifo_data = '0;
    logic                 m_valid;
    logic                 m_ready;
    logic [WIDTH-1:0]     m_data;
    logic                 idle;
    logic [CNT_WIDTH-1:0] drain_count;

    always #5 clk = ~clk;

    fifo_stream_reader #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .fifo_empty  (fifo_empty),
        .fifo_pop    (fifo_pop),
        .fifo_data   (fifo_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .idle        (idle),
        .drain_count (drain_count)
    );

    logic [WIDTH-1:0] fifo_q [$];
    logic [WIDTH-1:0] exp_q  [$];

    // Source FIFO: data_out and the empty flag are both registered.
    always @(posedge clk) begin
        if (fifo_pop && fifo_q.size() != 0) fifo_data <= fifo_q.pop_front();
        fifo_empty <= (fifo_q.size() == 0);
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc, pops, delivered, first_pop, first_valid, last_valid, valid_cnt, viol, occ;
    bit prev_stall;
    logic [WIDTH-1:0] prev_data;

    task automatic sb_clear();
        cyc = 0; pops = 0; delivered = 0; first_pop = -1; first_valid = -1;
        last_valid = -1; valid_cnt = 0; viol = 0; occ = 0; prev_stall = 0; prev_data = '0;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; enable = 1'b0; m_ready = 1'b0;
        fifo_q.delete(); exp_q.delete();
        sb_clear();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    // Runs up to max_cyc cycles (stopping once target words are delivered when target>0),
    // scoring every handshake against pop order and tallying protocol violations.
    task automatic drain_loop(input int max_cyc, input int target, input bit rnd);
        for (int i = 0; i < max_cyc; i++) begin
            if (rnd) begin
                enable  = 1'($urandom_range(0, 1));
                m_ready = 1'($urandom_range(0, 1));
            end
            #1;
            if (fifo_pop && fifo_empty) viol++;
            if (prev_stall && (!m_valid || m_data !== prev_data)) viol++;
            if (fifo_pop) begin
                pops++;
                if (first_pop < 0) first_pop = cyc;
            end
            if (m_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = cyc;
                last_valid = cyc;
            end
            if (m_valid && m_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL stream_order: got %h, required no word", m_data);
                end else begin
                    if (m_data !== exp_q[0]) begin
                        n_err++;
                        $display("FAIL stream_order: got %h, required %h", m_data, exp_q[0]);
                    end
                    exp_q.delete(0);
                end
                delivered++;
            end
            occ = occ + (fifo_pop ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
            if (occ > 2 || occ < 0) viol++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            @(posedge clk); #1;
            cyc++;
            if (target > 0 && delivered >= target) break;
        end
    endtask

    task automatic test_reset();
        do_reset();
        push_word(16'h5555);
        enable = 1'b1; m_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid: got %b, required 0", m_valid); end
        n_cmp++; if (m_data !== 16'h0) begin n_err++; $display("FAIL reset_m_data: got %h, required 0000", m_data); end
        n_cmp++; if (fifo_pop !== 1'b0) begin n_err++; $display("FAIL reset_fifo_pop: got %b, required 0", fifo_pop); end
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL reset_idle: got %b, required 1", idle); end
        n_cmp++; if (drain_count !== 16'd0) begin n_err++; $display("FAIL reset_drain_count: got %0d, required 0", drain_count); end
    endtask

    task automatic test_single_word();
        do_reset();
        push_word(16'h00A5);
        enable = 1'b1; m_ready = 1'b1;
        release_reset();
        drain_loop(12, 1, 1'b0);
        n_cmp++; if (delivered !== 1) begin n_err++; $display("FAIL single_delivered: got %0d, required 1", delivered); end
        n_cmp++; if (pops !== 1) begin n_err++; $display("FAIL single_pops: got %0d, required 1", pops); end
        n_cmp++; if (first_valid - first_pop !== 2) begin n_err++; $display("FAIL single_latency: got %0d, required 2", first_valid - first_pop); end
        n_cmp++; if (valid_cnt !== 1) begin n_err++; $display("FAIL single_valid_cycles: got %0d, required 1", valid_cnt); end
        n_cmp++; if (drain_count !== 16'd1) begin n_err++; $display("FAIL single_drain_count: got %0d, required 1", drain_count); end
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL single_idle: got %b, required 1", idle); end
    endtask

    task automatic test_streaming();
        do_reset();
        for (int i = 1; i <= 8; i++) push_word(16'(i));
        enable = 1'b1; m_ready = 1'b1;
        release_reset();
        drain_loop(40, 8, 1'b0);
        n_cmp++; if (valid_cnt !== 8) begin n_err++; $display("FAIL stream_valid_cycles: got %0d, required 8", valid_cnt); end
        n_cmp++; if (last_valid - first_valid !== 7) begin n_err++; $display("FAIL stream_contiguous: got span %0d, required 7", last_valid - first_valid); end
        n_cmp++; if (drain_count !== 16'd8) begin n_err++; $display("FAIL stream_drain_count: got %0d, required 8", drain_count); end
        n_cmp++; if (viol !== 0) begin n_err++; $display("FAIL stream_protocol: got %0d violations, required 0", viol); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 1; i <= 8; i++) push_word(16'(i));
        enable = 1'b1; m_ready = 1'b0;
        release_reset();
        drain_loop(8, 0, 1'b0);
        n_cmp++; if (pops !== 2) begin n_err++; $display("FAIL bp_pops: got %0d, required 2", pops); end
        n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL bp_m_valid: got %b, required 1", m_valid); end
        n_cmp++; if (m_data !== 16'h0001) begin n_err++; $display("FAIL bp_m_data: got %h, required 0001", m_data); end
        n_cmp++; if (fifo_pop !== 1'b0) begin n_err++; $display("FAIL bp_fifo_pop: got %b, required 0", fifo_pop); end
        m_ready = 1'b1;
        drain_loop(40, 8, 1'b0);
        n_cmp++; if (delivered !== 8) begin n_err++; $display("FAIL bp_delivered: got %0d, required 8", delivered); end
        n_cmp++; if (drain_count !== 16'd8) begin n_err++; $display("FAIL bp_drain_count: got %0d, required 8", drain_count); end
        n_cmp++; if (viol !== 0) begin n_err++; $display("FAIL bp_protocol: got %0d violations, required 0", viol); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 100; i++) push_word(16'(i * 16'h0137 + 16'h0021));
        release_reset();
        drain_loop(3000, 100, 1'b1);
        m_ready = 1'b1;
        n_cmp++; if (delivered !== 100) begin n_err++; $display("FAIL rand_delivered: got %0d, required 100", delivered); end
        n_cmp++; if (drain_count !== 16'd100) begin n_err++; $display("FAIL rand_drain_count: got %0d, required 100", drain_count); end
        n_cmp++; if (viol !== 0) begin n_err++; $display("FAIL rand_protocol: got %0d violations, required 0", viol); end
    endtask

    task automatic test_enable_edge();
        do_reset();
        for (int i = 0; i < 3; i++) push_word(16'hE000 + 16'(i));
        enable = 1'b1; m_ready = 1'b1;
        release_reset();
        drain_loop(1, 0, 1'b0);
        enable = 1'b0;
        drain_loop(8, 0, 1'b0);
        n_cmp++; if (pops !== 1) begin n_err++; $display("FAIL en_pops: got %0d, required 1", pops); end
        n_cmp++; if (delivered !== 1) begin n_err++; $display("FAIL en_delivered: got %0d, required 1", delivered); end
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL en_idle: got %b, required 1", idle); end
    endtask

    task automatic test_empty_midstream();
        do_reset();
        for (int i = 0; i < 3; i++) push_word(16'hC000 + 16'(i));
        enable = 1'b1; m_ready = 1'b1;
        release_reset();
        drain_loop(8, 0, 1'b0);
        n_cmp++; if (pops !== 3) begin n_err++; $display("FAIL empty_pops: got %0d, required 3", pops); end
        n_cmp++; if (delivered !== 3) begin n_err++; $display("FAIL empty_delivered: got %0d, required 3", delivered); end
        push_word(16'hC003);
        push_word(16'hC004);
        drain_loop(12, 5, 1'b0);
        n_cmp++; if (delivered !== 5) begin n_err++; $display("FAIL empty_resume: got %0d, required 5", delivered); end
        n_cmp++; if (viol !== 0) begin n_err++; $display("FAIL empty_protocol: got %0d violations, required 0", viol); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 1; i <= 8; i++) push_word(16'hA000 + 16'(i));
        enable = 1'b1; m_ready = 1'b1;
        release_reset();
        drain_loop(3, 0, 1'b0);
        n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL arst_pre_valid: got %b, required 1", m_valid); end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL arst_m_valid: got %b, required 0", m_valid); end
        n_cmp++; if (fifo_pop !== 1'b0) begin n_err++; $display("FAIL arst_fifo_pop: got %b, required 0", fifo_pop); end
        n_cmp++; if (drain_count !== 16'd0) begin n_err++; $display("FAIL arst_drain_count: got %0d, required 0", drain_count); end
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL arst_idle: got %b, required 1", idle); end
        fifo_q.delete(); exp_q.delete();
        sb_clear();
        repeat (2) @(posedge clk);
        #1;
        push_word(16'h1234);
        release_reset();
        drain_loop(12, 1, 1'b0);
        n_cmp++; if (delivered !== 1) begin n_err++; $display("FAIL arst_fresh_word: got %0d delivered, required 1", delivered); end
        n_cmp++; if (drain_count !== 16'd1) begin n_err++; $display("FAIL arst_fresh_count: got %0d, required 1", drain_count); end
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; m_ready = 1'b0;
        test_reset();
        test_single_word();
        test_streaming();
        test_backpressure();
        test_random();
        test_enable_edge();
        test_empty_midstream();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
